// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the 32-bit bus CPU.
// Steps through RESET, fetch (T0..T2), execute (T3..T7) and HALT, one step
// per clock, and decodes every datapath enable/select from the current
// step and the opcode ir[31:27].
// Optional build macro: CU_MULDIV_EN enables the mul/div execute sequence;
// without it mul/div decode as nop.
module control_sequencer #(
  parameter int unsigned RESET_STEPS = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        stop,
  output logic        run,
  output logic [4:0]  opcode,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        Yin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        PCout,
  output logic        IncPC,
  output logic        IRin,
  output logic        R8_RAin,
  output logic        CONin,
  output logic        InPortout,
  output logic        Out_portIn
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t      state;
  state_t      last_step;
  logic [31:0] rst_cnt;
  logic [4:0]  op;
  logic        is_md;
  logic        unused_ir_bits;

  assign op             = ir[31:27];
  assign unused_ir_bits = ^ir[26:0];

`ifdef CU_MULDIV_EN
  assign is_md = (op == OP_MUL) || (op == OP_DIV);
`else
  assign is_md = 1'b0;
`endif

  // Final execute step of the current instruction (T2 for nop/undefined).
  always_comb begin
    last_step = S_T2;
    case (op) inside
      OP_LD, OP_ST:                              last_step = S_T7;
      OP_LDI, [OP_ADD:OP_SHL], [OP_ADDI:OP_ORI]: last_step = S_T5;
      OP_BR:                                     last_step = S_T6;
      OP_NEG, OP_NOT, OP_JAL:                    last_step = S_T4;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:    last_step = S_T3;
      default:                                   last_step = S_T2;
    endcase
    if (is_md) last_step = S_T6;
  end

  // Step sequencing: reset idle count, fetch/execute advance, halt entry.
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= S_RESET;
      rst_cnt <= '0;
    end else begin
      case (state)
        S_RESET: begin
          if (rst_cnt + 32'd1 >= RESET_STEPS) state <= S_T0;
          else rst_cnt <= rst_cnt + 32'd1;
        end
        S_HALT: state <= S_HALT;
        default: begin
          if (state == S_T2 && op == OP_HALT) state <= S_HALT;
          else if (state == last_step)        state <= stop ? S_HALT : S_T0;
          else                                state <= state_t'(state + 4'd1);
        end
      endcase
    end
  end

  // Control decode from the registered step and the opcode.
  always_comb begin
    {read, write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, HIin, HIout, LOin,
     LOout, Zin, Zhighout, Zlowout, Yin, MDRin, MDRout, MARin, PCin, PCout,
     IncPC, IRin, R8_RAin, CONin, InPortout, Out_portIn} = '0;
    run    = (state != S_RESET) && (state != S_HALT);
    opcode = run ? OP_ADD : 5'b00000;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1: begin read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_md) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else begin
          case (op) inside
            OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            [OP_ADD:OP_SHL], [OP_ADDI:OP_ORI]: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            OP_NEG, OP_NOT: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
            OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_JAL:  begin PCout = 1'b1; R8_RAin = 1'b1; end
            OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; Out_portIn = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (is_md) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op;
        end else begin
          case (op) inside
            OP_LD, OP_LDI, OP_ST: begin Cout = 1'b1; Zin = 1'b1; end
            [OP_ADD:OP_SHL]:   begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
            [OP_ADDI:OP_ORI]:  begin Cout = 1'b1; Zin = 1'b1; opcode = op; end
            OP_NEG, OP_NOT:    begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_BR:             begin PCout = 1'b1; Yin = 1'b1; end
            OP_JAL:            begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T5: begin
        if (is_md) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else begin
          case (op) inside
            OP_LD, OP_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
            OP_LDI, [OP_ADD:OP_SHL], [OP_ADDI:OP_ORI]: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_BR: begin Cout = 1'b1; Zin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T6: begin
        if (is_md) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end else begin
          case (op)
            OP_LD: begin read = 1'b1; MDRin = 1'b1; end
            OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            OP_BR: begin Zlowout = con; PCin = con; end
            default: ;
          endcase
        end
      end
      S_T7: begin
        case (op)
          OP_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST: begin MDRout = 1'b1; write = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer.
// A driver issues instructions (directed, then random) and pushes the
// expected per-cycle control word from a microprogram-table model; a monitor
// pops and compares one word every cycle on the falling edge.
module tb_control_sequencer;

  localparam int unsigned RESET_STEPS = 2;
`ifdef CU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  localparam logic [27:0] M_READ  = 28'd1 << 0,  M_WRITE = 28'd1 << 1;
  localparam logic [27:0] M_GRA   = 28'd1 << 2,  M_GRB   = 28'd1 << 3;
  localparam logic [27:0] M_GRC   = 28'd1 << 4,  M_RIN   = 28'd1 << 5;
  localparam logic [27:0] M_ROUT  = 28'd1 << 6,  M_BAOUT = 28'd1 << 7;
  localparam logic [27:0] M_COUT  = 28'd1 << 8,  M_HIIN  = 28'd1 << 9;
  localparam logic [27:0] M_HIOUT = 28'd1 << 10, M_LOIN  = 28'd1 << 11;
  localparam logic [27:0] M_LOOUT = 28'd1 << 12, M_ZIN   = 28'd1 << 13;
  localparam logic [27:0] M_ZHI   = 28'd1 << 14, M_ZLO   = 28'd1 << 15;
  localparam logic [27:0] M_YIN   = 28'd1 << 16, M_MDRIN = 28'd1 << 17;
  localparam logic [27:0] M_MDROUT= 28'd1 << 18, M_MARIN = 28'd1 << 19;
  localparam logic [27:0] M_PCIN  = 28'd1 << 20, M_PCOUT = 28'd1 << 21;
  localparam logic [27:0] M_INCPC = 28'd1 << 22, M_IRIN  = 28'd1 << 23;
  localparam logic [27:0] M_RAIN  = 28'd1 << 24, M_CONIN = 28'd1 << 25;
  localparam logic [27:0] M_INP   = 28'd1 << 26, M_OUTP  = 28'd1 << 27;

  logic clock, clear, con, stop;
  logic [31:0] ir;
  logic run, read, write, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic HIin, HIout, LOin, LOout, Zin, Zhighout, Zlowout, Yin;
  logic MDRin, MDRout, MARin, PCin, PCout, IncPC, IRin, R8_RAin, CONin;
  logic InPortout, Out_portIn;
  logic [4:0] opcode;
  logic [33:0] obs;

  typedef struct {
    logic [33:0] w;
    logic [4:0]  op;
    int          step;
  } exp_t;

  exp_t        sb[$];
  logic [33:0] prog[$];
  int          tests = 0;
  int          failed = 0;

  control_sequencer #(.RESET_STEPS(RESET_STEPS)) dut (
    .clock(clock), .clear(clear), .ir(ir), .con(con), .stop(stop),
    .run(run), .opcode(opcode), .read(read), .write(write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Cout(Cout), .HIin(HIin), .HIout(HIout),
    .LOin(LOin), .LOout(LOout), .Zin(Zin), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .Yin(Yin), .MDRin(MDRin), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .PCout(PCout), .IncPC(IncPC),
    .IRin(IRin), .R8_RAin(R8_RAin), .CONin(CONin),
    .InPortout(InPortout), .Out_portIn(Out_portIn)
  );

  assign obs = {run, opcode, Out_portIn, InPortout, CONin, R8_RAin, IRin,
                IncPC, PCout, PCin, MARin, MDRout, MDRin, Yin, Zlowout,
                Zhighout, Zin, LOout, LOin, HIout, HIin, Cout, BAout, Rout,
                Rin, Grc, Grb, Gra, write, read};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [33:0] w(input logic [27:0] m);
    return {1'b1, 5'b00011, m};
  endfunction

  function automatic logic [33:0] wa(input logic [4:0] op, input logic [27:0] m);
    return {1'b1, op, m};
  endfunction

  // Reference microprogram: the full list of control words for one instruction.
  task automatic build_prog(input logic [4:0] op, input logic c);
    prog.delete();
    prog.push_back(w(M_PCOUT | M_MARIN | M_INCPC));
    prog.push_back(w(M_READ | M_MDRIN));
    prog.push_back(w(M_MDROUT | M_IRIN));
    if (op <= 5'd2) begin
      prog.push_back(w(M_GRB | M_BAOUT | M_YIN));
      prog.push_back(w(M_COUT | M_ZIN));
      if (op == 5'd1) prog.push_back(w(M_ZLO | M_GRA | M_RIN));
      else begin
        prog.push_back(w(M_ZLO | M_MARIN));
        if (op == 5'd0) begin
          prog.push_back(w(M_READ | M_MDRIN));
          prog.push_back(w(M_MDROUT | M_GRA | M_RIN));
        end else begin
          prog.push_back(w(M_GRA | M_ROUT | M_MDRIN));
          prog.push_back(w(M_MDROUT | M_WRITE));
        end
      end
    end else if (op <= 5'd14) begin
      prog.push_back(w(M_GRB | M_ROUT | M_YIN));
      prog.push_back(wa(op, ((op >= 5'd12) ? M_COUT : (M_GRC | M_ROUT)) | M_ZIN));
      prog.push_back(w(M_ZLO | M_GRA | M_RIN));
    end else if (op == 5'd15 || op == 5'd16) begin
      if (MULDIV) begin
        prog.push_back(w(M_GRA | M_ROUT | M_YIN));
        prog.push_back(wa(op, M_GRB | M_ROUT | M_ZIN));
        prog.push_back(w(M_ZLO | M_LOIN));
        prog.push_back(w(M_ZHI | M_HIIN));
      end
    end else if (op == 5'd17 || op == 5'd18) begin
      prog.push_back(wa(op, M_GRB | M_ROUT | M_ZIN));
      prog.push_back(w(M_ZLO | M_GRA | M_RIN));
    end else if (op == 5'd19) begin
      prog.push_back(w(M_GRA | M_ROUT | M_CONIN));
      prog.push_back(w(M_PCOUT | M_YIN));
      prog.push_back(w(M_COUT | M_ZIN));
      prog.push_back(w(c ? (M_ZLO | M_PCIN) : 28'd0));
    end else if (op == 5'd20) prog.push_back(w(M_GRA | M_ROUT | M_PCIN));
    else if (op == 5'd21) begin
      prog.push_back(w(M_PCOUT | M_RAIN));
      prog.push_back(w(M_GRA | M_ROUT | M_PCIN));
    end
    else if (op == 5'd22) prog.push_back(w(M_INP | M_GRA | M_RIN));
    else if (op == 5'd23) prog.push_back(w(M_GRA | M_ROUT | M_OUTP));
    else if (op == 5'd24) prog.push_back(w(M_HIOUT | M_GRA | M_RIN));
    else if (op == 5'd25) prog.push_back(w(M_LOOUT | M_GRA | M_RIN));
  endtask

  task automatic push_zero(input logic [4:0] op);
    exp_t e;
    e.w = '0; e.op = op; e.step = -1;
    sb.push_back(e);
  endtask

  // Holds clear for 'hold' cycles (state already RESET), then the idle steps.
  task automatic reset_tail(input int hold);
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      if (h == hold - 1) clear = 1'b0;
      stop = 1'($urandom);
      push_zero(5'd0);
    end
    for (int unsigned k = 1; k < RESET_STEPS; k++) begin
      @(posedge clock); #1;
      push_zero(5'd0);
    end
  endtask

  // From HALT: a few idle cycles, then clear.
  task automatic leave_halt(input int idle, input int hold);
    for (int k = 0; k < idle; k++) begin
      @(posedge clock); #1;
      ir = $urandom; stop = 1'($urandom); con = 1'($urandom);
      push_zero(5'd27);
    end
    @(posedge clock); #1;
    clear = 1'b1;
    push_zero(5'd27);
    reset_tail(hold);
  endtask

  // ended: 0 back to fetch, 1 halted, 2 aborted by clear (clear left high).
  task automatic run_instr(input logic [31:0] irv, input logic c, input logic s,
                           input int abort_step, output int ended);
    exp_t e;
    logic [4:0] op;
    int n;
    op = irv[31:27];
    build_prog(op, c);
    n = prog.size();
    ended = (s || op == 5'd27) ? 1 : 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      ir   = (i < 2) ? $urandom : irv;
      con  = c;
      stop = (i == n - 1) ? s : 1'($urandom);
      e.w = prog[i]; e.op = op; e.step = i;
      sb.push_back(e);
      if (i == abort_step) begin
        clear = 1'b1;
        ended = 2;
        break;
      end
    end
  endtask

  // Monitor: one comparison per cycle while expectations are queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (obs !== e.w) begin
          failed++;
          $display("FAIL ctrl_word op=%b step=%0d got=%h expected=%h t=%0t",
                   e.op, e.step, obs, e.w, $time);
        end
      end
    end
  end

  initial begin
    int ended;
    logic [4:0] op;
    logic [31:0] irv;
    int ab;
    clear = 1'b1; ir = '0; con = 1'b0; stop = 1'b0;
    reset_tail(2);

    run_instr(32'h18918000, 1'b0, 1'b0, -1, ended);   // add
    run_instr(32'h12080090, 1'b1, 1'b0, -1, ended);   // st
    run_instr(32'h99000023, 1'b1, 1'b0, -1, ended);   // branch taken
    run_instr(32'h99000023, 1'b0, 1'b0, -1, ended);   // branch not taken
    run_instr(32'h81880000, 1'b0, 1'b0, -1, ended);   // mul
    run_instr(32'h18918000, 1'b0, 1'b1, -1, ended);   // add with stop
    leave_halt(4, 2);
    run_instr(32'hD8000000, 1'b0, 1'b0, -1, ended);   // halt
    leave_halt(10, 1);
    run_instr(32'h00880010, 1'b0, 1'b0, 4, ended);    // ld cleared in T4
    reset_tail(2);
    run_instr(32'hD0000000, 1'b0, 1'b0, -1, ended);   // nop

    for (int n = 0; n < 300; n++) begin
      op  = 5'($urandom_range(0, 31));
      irv = {op, 27'($urandom)};
      ab  = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr(irv, 1'($urandom), ($urandom_range(0, 9) == 0), ab, ended);
      if (ended == 1) leave_halt(int'($urandom_range(0, 4)), int'($urandom_range(1, 3)));
      else if (ended == 2) reset_tail(int'($urandom_range(1, 3)));
    end

    repeat (2) @(posedge clock);
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain got=%0d left expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
